serial_add_sub: RTL and testbench

Parametrised multi-cycle two's-complement arithmetic unit. It is the sequential successor to the team's 4-bit combinational two's-complement and adder/subtractor blocks. Operands are processed DIGIT bits per clock with a single shared ripple slice, trading latency for area. Supported operations are add, subtract, negate and absolute value, with start/busy/done handshake and status flags.

---
 rtl/serial_add_sub.sv | 146 ++++++++++++++
 tb/tb_serial_add_sub.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle two's-complement add/sub/neg/abs unit.
// One DIGIT-bit ripple slice is reused for WIDTH/DIGIT cycles; operands are
// pre-conditioned at accept time so every op reduces to X + Y + c0.
module serial_add_sub #(
  parameter int WIDTH = 4,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_err
    $error("serial_add_sub: WIDTH must be >= 2 and DIGIT must divide WIDTH");
  end

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  x_q, y_q, sr_q;
  logic              carry_q;
  logic [CW-1:0]     cnt_q;
  logic              done_q, cout_q, ovf_q, zero_q;
  logic [WIDTH-1:0]  result_q;

  logic [WIDTH-1:0]  x_d, y_d;
  logic              c0_d;
  logic [DIGIT-1:0]  sum_d;
  logic              carry_d;
  logic              cmsb_d;
  logic [WIDTH-1:0]  sr_d;
  logic              last_d;

  // Map the requested op onto X + Y + c0 (subtract/negate via invert-plus-one).
  always_comb begin
    x_d  = a;
    y_d  = b;
    c0_d = 1'b0;
    case (op)
      2'b00: ;
      2'b01: begin
        y_d  = ~b;
        c0_d = 1'b1;
      end
      2'b10: begin
        x_d  = ~a;
        y_d  = '0;
        c0_d = 1'b1;
      end
      default: begin
        y_d = '0;
        if (a[WIDTH-1]) begin
          x_d  = ~a;
          c0_d = 1'b1;
        end
      end
    endcase
  end

  // Shared ripple slice over the low DIGIT bits; cmsb_d keeps the carry into
  // the slice's top bit, which on the final digit is the carry into the MSB.
  always_comb begin : slice
    logic cy;
    cy     = carry_q;
    sum_d  = '0;
    cmsb_d = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      sum_d[i] = x_q[i] ^ y_q[i] ^ cy;
      cmsb_d   = cy;
      cy       = (x_q[i] & y_q[i]) | (cy & (x_q[i] ^ y_q[i]));
    end
    carry_d = cy;
  end

  // New sum digit enters at the top; after N shifts the LSB digit sits at bit 0.
  always_comb begin
    sr_d   = WIDTH'({sum_d, sr_q} >> DIGIT);
    last_d = (cnt_q == CW'(N - 1));
  end

  // Control FSM plus datapath registers; flags are updated only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      sr_q     <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= x_d;
            y_q     <= y_d;
            carry_q <= c0_d;
            sr_q    <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        default: begin
          x_q     <= x_q >> DIGIT;
          y_q     <= y_q >> DIGIT;
          sr_q    <= sr_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (last_d) begin
            state_q  <= IDLE;
            done_q   <= 1'b1;
            result_q <= sr_d;
            cout_q   <= carry_d;
            ovf_q    <= cmsb_d ^ carry_d;
            zero_q   <= (sr_d == '0);
          end
        end
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: scoreboard bench for serial_add_sub (4x1 and 8x2 configs).
module tb_serial_add_sub;

  localparam int N4 = 4;  // WIDTH=4, DIGIT=1
  localparam int N8 = 4;  // WIDTH=8, DIGIT=2

  typedef struct {
    int r;
    bit c;
    bit v;
    bit z;
  } exp_t;

  logic       clk, rst_n;
  logic       st4, st8;
  logic [1:0] op4, op8;
  logic [3:0] a4, b4, r4;
  logic [7:0] a8, b8, r8;
  logic       bz4, dn4, c4, v4, z4;
  logic       bz8, dn8, c8, v8, z8;

  int   checks = 0;
  int   fails  = 0;
  exp_t q4[$];
  exp_t q8[$];

  serial_add_sub #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .op(op4), .a(a4), .b(b4),
    .busy(bz4), .done(dn4), .result(r4), .carry_out(c4), .overflow(v4), .zero(z4)
  );

  serial_add_sub #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .op(op8), .a(a8), .b(b8),
    .busy(bz8), .done(dn8), .result(r8), .carry_out(c8), .overflow(v8), .zero(z8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, signed overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [1:0] o, input int av, input int bv);
    exp_t e;
    int m, mn, s;
    bit sa, sb, sr;
    m  = (1 << w) - 1;
    mn = 1 << (w - 1);
    case (o)
      2'b00:   s = av + bv;
      2'b01:   s = av + ((~bv) & m) + 1;
      2'b10:   s = ((~av) & m) + 1;
      default: s = ((av & mn) != 0) ? ((~av) & m) + 1 : av;
    endcase
    e.r = s & m;
    e.c = ((s >> w) & 1) != 0;
    sa  = (av & mn) != 0;
    sb  = (bv & mn) != 0;
    sr  = (e.r & mn) != 0;
    case (o)
      2'b00:   e.v = (sa == sb) && (sr != sa);
      2'b01:   e.v = (sa != sb) && (sr != sa);
      default: e.v = (av == mn);
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  task automatic run_op(input int w, input logic [1:0] o, input int av, input int bv, input string nm);
    exp_t e;
    int   cyc, n;
    bit   seen, bz;
    logic [7:0] ar;
    logic ac, avf, az;
    n = (w == 4) ? N4 : N8;
    @(negedge clk);
    if (w == 4) begin st4 = 1'b1; op4 = o; a4 = 4'(av); b4 = 4'(bv); end
    else        begin st8 = 1'b1; op8 = o; a8 = 8'(av); b8 = 8'(bv); end
    @(posedge clk);
    if (w == 4) q4.push_back(model(4, o, av, bv));
    else        q8.push_back(model(8, o, av, bv));
    #1;
    bz = (w == 4) ? bz4 : bz8;
    checks++; if (bz !== 1'b1) begin fails++; $display("FAIL %s busy_after_start: got %b expected 1", nm, bz); end
    @(negedge clk);
    st4 = 1'b0; st8 = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 3 * n + 4) begin
      @(posedge clk); #1;
      cyc++;
      seen = (w == 4) ? dn4 : dn8;
    end
    e = (w == 4) ? q4.pop_front() : q8.pop_front();
    checks++;
    if (!seen) begin
      fails++; $display("FAIL %s done_timeout: no done within %0d cycles", nm, cyc);
    end else begin
      ar  = (w == 4) ? {4'b0, r4} : r8;
      ac  = (w == 4) ? c4 : c8;
      avf = (w == 4) ? v4 : v8;
      az  = (w == 4) ? z4 : z8;
      if (cyc != n) begin fails++; $display("FAIL %s latency: got %0d expected %0d", nm, cyc, n); end
      checks++; if (ar !== 8'(e.r)) begin fails++; $display("FAIL %s result: got %0h expected %0h", nm, ar, 8'(e.r)); end
      checks++; if (ac !== e.c) begin fails++; $display("FAIL %s carry_out: got %b expected %b", nm, ac, e.c); end
      checks++; if (avf !== e.v) begin fails++; $display("FAIL %s overflow: got %b expected %b", nm, avf, e.v); end
      checks++; if (az !== e.z) begin fails++; $display("FAIL %s zero: got %b expected %b", nm, az, e.z); end
      @(posedge clk); #1;
      checks++; if (((w == 4) ? dn4 : dn8) !== 1'b0) begin fails++; $display("FAIL %s done_pulse_width: got 1 expected 0", nm); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    st4 = 0; st8 = 0; op4 = 0; op8 = 0; a4 = 0; b4 = 0; a8 = 0; b8 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({bz4, dn4, r4, c4, v4, z4} !== 9'b0) begin fails++; $display("FAIL reset_dut4: got %b expected 0", {bz4, dn4, r4, c4, v4, z4}); end
    checks++; if ({bz8, dn8, r8, c8, v8, z8} !== 13'b0) begin fails++; $display("FAIL reset_dut8: got %b expected 0", {bz8, dn8, r8, c8, v8, z8}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_neg_sweep();
    for (int i = 0; i < 16; i++) run_op(4, 2'b10, i, 0, $sformatf("neg_%0d", i));
  endtask

  task automatic test_add_sub_abs();
    run_op(4, 2'b01, 4'b0011, 4'b0101, "sub_3_5");
    run_op(4, 2'b01, 4'b0101, 4'b0011, "sub_5_3");
    run_op(4, 2'b00, 4'b0111, 4'b0001, "add_7_1");
    run_op(4, 2'b00, 4'b1111, 4'b0001, "add_f_1");
    run_op(4, 2'b11, 4'b1011, 0, "abs_b");
    run_op(4, 2'b11, 4'b0110, 0, "abs_6");
    run_op(4, 2'b11, 4'b1000, 0, "abs_8");
  endtask

  // start held high with operands changing every cycle: accepts at t=0 and at
  // the edge closing the done cycle (t=N+1); everything in between is ignored.
  task automatic test_back_to_back();
    exp_t e;
    int   av, bv;
    bit   dexp, bexp;
    logic [3:0] held;
    held = 4'b0;
    for (int t = 0; t <= 3 * N4 + 3; t++) begin
      @(negedge clk);
      av = (t * 5 + 3) & 15;
      bv = (t * 3 + 1) & 15;
      st4 = (t <= N4 + 1); op4 = 2'b00; a4 = 4'(av); b4 = 4'(bv);
      @(posedge clk);
      if (t == 0 || t == N4 + 1) q4.push_back(model(4, 2'b00, av, bv));
      #1;
      dexp = (t == N4) || (t == 2 * N4 + 1);
      bexp = (t < N4) || (t >= N4 + 1 && t < 2 * N4 + 1);
      checks++; if (dn4 !== dexp) begin fails++; $display("FAIL b2b done_t%0d: got %b expected %b", t, dn4, dexp); end
      checks++; if (bz4 !== bexp) begin fails++; $display("FAIL b2b busy_t%0d: got %b expected %b", t, bz4, bexp); end
      if (dn4 === 1'b1 && q4.size() > 0) begin
        e = q4.pop_front();
        held = 4'(e.r);
        checks++; if (r4 !== 4'(e.r)) begin fails++; $display("FAIL b2b result_t%0d: got %h expected %h", t, r4, 4'(e.r)); end
      end
      if (t == N4 + 2) begin
        checks++; if (r4 !== held) begin fails++; $display("FAIL b2b result_hold: got %h expected %h", r4, held); end
      end
    end
    st4 = 1'b0;
    checks++; if (q4.size() != 0) begin fails++; $display("FAIL b2b scoreboard_left: got %0d expected 0", q4.size()); end
    q4.delete();
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    @(negedge clk);
    st4 = 1'b1; op4 = 2'b10; a4 = 4'd3;
    @(posedge clk);
    @(negedge clk);
    st4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bz4 !== 1'b1) begin fails++; $display("FAIL rst_mid busy_before: got %b expected 1", bz4); end
    checks++; if (r4 === 4'b0) begin fails++; $display("FAIL rst_mid result_before: got %h expected nonzero", r4); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({bz4, dn4} !== 2'b0) begin fails++; $display("FAIL rst_mid busy_done: got %b expected 00", {bz4, dn4}); end
    checks++; if ({r4, c4, v4, z4} !== 7'b0) begin fails++; $display("FAIL rst_mid result_flags: got %b expected 0", {r4, c4, v4, z4}); end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (3 * N4) begin
      @(posedge clk); #1;
      if (dn4 === 1'b1 || bz4 === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin fails++; $display("FAIL rst_mid late_activity: got %0d expected 0", pulses); end
  endtask

  task automatic test_wide();
    run_op(8, 2'b00, 'h7F, 'h01, "w8_add_7f_1");
    run_op(8, 2'b01, 'h10, 'h20, "w8_sub_10_20");
    run_op(8, 2'b10, 'h80, 0, "w8_neg_80");
    run_op(8, 2'b11, 'hF6, 0, "w8_abs_f6");
    run_op(8, 2'b10, 'h00, 0, "w8_neg_0");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_neg_sweep();
    test_add_sub_abs();
    test_back_to_back();
    test_reset_mid_run();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
